// File: rtl/spart_io_sequencer.sv
// spart_io_sequencer: SPART bus master that programs the baud divisor, sends keyboard bytes and reads RX bytes.
// Define ECHO_EN to push every received byte back into the TX FIFO.
module spart_io_sequencer #(
   parameter int FIFO_DEPTH = 8,
   parameter int TBR_HOLD   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] br_cfg,
   input  logic       kbd_rda,
   input  logic [7:0] kbd_databus,
   input  logic       rda,
   input  logic       tbr,
   output logic       iocs,
   output logic       iorw,
   output logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       cfg_done,
   output logic       overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = $clog2(TBR_HOLD + 2);

   typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RX_RD, TX_WR} state_t;

   state_t          state_q, state_d;
   logic [1:0]      br_s1_q, br_s2_q, br_reg_q, br_reg_d;
   logic            iocs_q, iocs_d, iorw_q, iorw_d;
   logic [1:0]      ioaddr_q, ioaddr_d;
   logic [7:0]      dout_q, dout_d;
   logic [7:0]      rx_byte_q;
   logic            rx_valid_q, cfg_done_q, cfg_done_d, overflow_q;
   logic            prio_rx_q, prio_rx_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   cnt_q;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic            kbd_q1, kbd_q2;
   logic [7:0]      kbd_data_q;
   logic            kbd_push, push_v, push_ok, pop, full, tx_req, rx_req;
   logic [7:0]      push_data;
   logic [15:0]     div_lo, div_hi;

   function automatic logic [15:0] div_f(input logic [1:0] b);
      return b == 2'b00 ? 16'h0515 : b == 2'b01 ? 16'h028A : b == 2'b10 ? 16'h0145 : 16'h00A2;
   endfunction

   assign div_lo    = div_f(br_s2_q);
   assign div_hi    = div_f(br_reg_q);
   assign kbd_push  = kbd_q1 & ~kbd_q2;
   assign full      = cnt_q == CW'(FIFO_DEPTH);
   assign push_ok   = push_v & (~full | pop);
   assign tx_req    = cfg_done_q && cnt_q != '0 && tbr && hold_q == '0;
   assign rx_req    = cfg_done_q && rda;

   assign iocs      = iocs_q;
   assign iorw      = iorw_q;
   assign ioaddr    = ioaddr_q;
   assign databus   = (iocs_q && !iorw_q) ? dout_q : 8'hzz;
   assign rx_byte   = rx_byte_q;
   assign rx_valid  = rx_valid_q;
   assign cfg_done  = cfg_done_q;
   assign overflow  = overflow_q;

`ifdef ECHO_EN
   logic       echo_v_q;
   logic [7:0] echo_q;
   // A keyboard push in the same cycle wins; the echo byte waits one more cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         echo_v_q <= 1'b0;
         echo_q   <= '0;
      end else begin
         echo_v_q <= (state_q == RX_RD) | (echo_v_q & kbd_push);
         if (state_q == RX_RD) echo_q <= databus;
      end
   end
   assign push_v    = kbd_push | echo_v_q;
   assign push_data = kbd_push ? kbd_data_q : echo_q;
`else
   assign push_v    = kbd_push;
   assign push_data = kbd_data_q;
`endif

   // DIP switch synchronizer runs through reset so br_cfg is valid on the first configuration write.
   always_ff @(posedge clk) begin
      br_s1_q <= br_cfg;
      br_s2_q <= br_s1_q;
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

   always_comb begin
      state_d    = state_q;
      iocs_d     = 1'b0;
      iorw_d     = 1'b1;
      ioaddr_d   = 2'b00;
      dout_d     = dout_q;
      br_reg_d   = br_reg_q;
      cfg_done_d = cfg_done_q;
      prio_rx_d  = prio_rx_q;
      hold_d     = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
      pop        = 1'b0;
      case (state_q)
         CFG_LO: begin
            state_d    = CFG_HI;
            iocs_d     = 1'b1;
            iorw_d     = 1'b0;
            ioaddr_d   = 2'b10;
            dout_d     = div_lo[7:0];
            br_reg_d   = br_s2_q;
            cfg_done_d = 1'b0;
         end
         CFG_HI: begin
            state_d  = IDLE;
            iocs_d   = 1'b1;
            iorw_d   = 1'b0;
            ioaddr_d = 2'b11;
            dout_d   = div_hi[15:8];
         end
         IDLE: begin
            if (br_s2_q != br_reg_q) begin
               cfg_done_d = 1'b0;
               state_d    = CFG_LO;
            end else begin
               cfg_done_d = 1'b1;
               if (rx_req && (prio_rx_q || !tx_req)) begin
                  state_d   = RX_RD;
                  iocs_d    = 1'b1;
                  prio_rx_d = 1'b0;
               end else if (tx_req) begin
                  state_d   = TX_WR;
                  iocs_d    = 1'b1;
                  iorw_d    = 1'b0;
                  dout_d    = mem_q[rd_ptr_q];
                  pop       = 1'b1;
                  hold_d    = HW'(TBR_HOLD);
                  prio_rx_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CFG_LO;
         br_reg_q   <= '0;
         iocs_q     <= 1'b0;
         iorw_q     <= 1'b1;
         ioaddr_q   <= 2'b00;
         dout_q     <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
         cfg_done_q <= 1'b0;
         overflow_q <= 1'b0;
         prio_rx_q  <= 1'b1;
         hold_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         kbd_q1     <= 1'b0;
         kbd_q2     <= 1'b0;
         kbd_data_q <= '0;
      end else begin
         state_q    <= state_d;
         br_reg_q   <= br_reg_d;
         iocs_q     <= iocs_d;
         iorw_q     <= iorw_d;
         ioaddr_q   <= ioaddr_d;
         dout_q     <= dout_d;
         rx_byte_q  <= (state_q == RX_RD) ? databus : rx_byte_q;
         rx_valid_q <= state_q == RX_RD;
         cfg_done_q <= cfg_done_d;
         overflow_q <= overflow_q | (push_v & full & ~pop);
         prio_rx_q  <= prio_rx_d;
         hold_q     <= hold_d;
         wr_ptr_q   <= wr_ptr_q + AW'(push_ok);
         rd_ptr_q   <= rd_ptr_q + AW'(pop);
         cnt_q      <= cnt_q + CW'(push_ok) - CW'(pop);
         kbd_q1     <= kbd_rda;
         kbd_q2     <= kbd_q1;
         kbd_data_q <= kbd_databus;
      end
   end
endmodule

// File: tb/tb_spart_io_sequencer.sv
// tb_spart_io_sequencer: bench for spart_io_sequencer; bus accesses are checked against a scoreboard queue.
// Build with ECHO_EN defined to also exercise the echo path.
module tb_spart_io_sequencer;
   localparam int DEPTH = 8;

   typedef struct packed {logic rw; logic [1:0] addr; logic [7:0] data;} acc_t;
   typedef struct {logic [1:0] br; logic [7:0] lo; logic [7:0] hi;} cfg_vec_t;

   logic       clk = 1'b0, rst = 1'b1;
   logic [1:0] br_cfg = 2'b01;
   logic       kbd_rda = 1'b0, rda = 1'b0, tbr = 1'b0;
   logic [7:0] kbd_databus = 8'h00, spart_rd = 8'h00, exp_rx = 8'h00;
   logic       iocs, iorw, rx_valid, cfg_done, overflow;
   logic [1:0] ioaddr;
   logic [7:0] rx_byte;
   wire  [7:0] databus;

   int   n_tests = 0, n_fail = 0, cyc = 0, last_tx = -100, rx_cnt = 0, rx0;
   acc_t exp_q[$];
   cfg_vec_t tbl[4];

   spart_io_sequencer #(.FIFO_DEPTH(DEPTH), .TBR_HOLD(2)) dut (
      .clk(clk), .rst(rst), .br_cfg(br_cfg), .kbd_rda(kbd_rda), .kbd_databus(kbd_databus),
      .rda(rda), .tbr(tbr), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
      .rx_byte(rx_byte), .rx_valid(rx_valid), .cfg_done(cfg_done), .overflow(overflow)
   );

   assign databus = (iocs && iorw) ? spart_rd : 8'hzz;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic exp_push(input logic rw, input logic [1:0] addr, input logic [7:0] data);
      exp_q.push_back('{rw, addr, data});
   endtask

   // Bus monitor / scoreboard: every SPART access must match the next expected one.
   always @(negedge clk) begin
      if (!rst && iocs) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected access: rw=%b addr=%b data=%h", iorw, ioaddr, databus);
         end else begin
            chk("bus access", {iorw, ioaddr, iorw ? 8'h00 : databus}, exp_q.pop_front());
         end
         if (!iorw && ioaddr == 2'b00) begin
            chk("tx spacing", 32'(cyc - last_tx >= 3), 1);
            last_tx = cyc;
         end
      end
      if (!rst && rx_valid) begin
         rx_cnt++;
         chk("rx_byte", rx_byte, exp_rx);
      end
   end

   task automatic drain(input int lim, input string nm);
      int k = 0;
      while (exp_q.size() != 0 && k < lim) begin
         @(posedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s timeout: %0d accesses outstanding, 0 required", nm, exp_q.size());
         exp_q.delete();
      end
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic wait_cfg(input logic v, input string nm);
      int k = 0;
      while (cfg_done !== v && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk(nm, cfg_done, v);
   endtask

   task automatic kbd_send(input logic [7:0] b);
      kbd_databus = b;
      kbd_rda = 1'b1;
      repeat (2) @(posedge clk);
      #1 kbd_rda = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] b;
      int k;
      tbl[0] = '{2'b11, 8'hA2, 8'h00};
      tbl[1] = '{2'b00, 8'h15, 8'h05};
      tbl[2] = '{2'b10, 8'h45, 8'h01};
      tbl[3] = '{2'b01, 8'h8A, 8'h02};

      repeat (4) @(posedge clk);
      #1;
      chk("reset iocs", iocs, 0);
      chk("reset iorw", iorw, 1);
      chk("reset ioaddr", ioaddr, 0);
      chk("reset rx_byte", rx_byte, 0);
      chk("reset rx_valid", rx_valid, 0);
      chk("reset cfg_done", cfg_done, 0);
      chk("reset overflow", overflow, 0);

      // Divisor programming straight out of reset
      exp_push(0, 2'b10, 8'h8A);
      exp_push(0, 2'b11, 8'h02);
      rst = 1'b0;
      @(negedge clk);
      chk("bus idle before first edge", iocs, 0);
      @(negedge clk);
      chk("cfg lo cycle 1", {iocs, iorw, ioaddr}, 4'b1010);
      @(negedge clk);
      chk("cfg hi cycle 2", {iocs, iorw, ioaddr}, 4'b1011);
      chk("cfg_done cycle 2", cfg_done, 0);
      @(negedge clk);
      chk("cfg_done cycle 3", cfg_done, 1);
      chk("bus idle cycle 3", iocs, 0);

      // Keyboard bytes: first one checks the 3-cycle latency
      tbr = 1'b1;
      @(posedge clk);
      #1;
      exp_push(0, 2'b00, 8'h1C);
      kbd_databus = 8'h1C;
      kbd_rda = 1'b1;
      repeat (3) @(negedge clk);
      chk("no tx before grant", iocs, 0);
      @(negedge clk);
      chk("tx latency 3", {iocs, iorw, ioaddr}, 4'b1000);
      @(posedge clk);
      #1 kbd_rda = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_push(0, 2'b00, 8'h32);
      kbd_send(8'h32);
      exp_push(0, 2'b00, 8'h21);
      kbd_send(8'h21);
      drain(40, "kbd tx");

      // Fill FIFO with tbr low, ninth byte overflows
      tbr = 1'b0;
      for (int i = 0; i <= DEPTH; i++) begin
         b = 8'h30 + 8'(i);
         if (i < DEPTH) exp_push(0, 2'b00, b);
         kbd_send(b);
         if (i == DEPTH - 1) chk("no overflow at exactly full", overflow, 0);
      end
      chk("fifo count full", 32'(dut.cnt_q), DEPTH);
      chk("overflow sticky", overflow, 1);
      tbr = 1'b1;
      drain(80, "fifo drain");
      chk("fifo empty after drain", 32'(dut.cnt_q), 0);

      // RX/TX round robin with both requesting
      tbr = 1'b0;
      kbd_send(8'hA0);
      kbd_send(8'hA1);
      spart_rd = 8'h41;
      exp_rx = 8'h41;
      rx0 = rx_cnt;
      exp_push(1, 2'b00, 8'h00);
      exp_push(0, 2'b00, 8'hA0);
      exp_push(1, 2'b00, 8'h00);
      exp_push(0, 2'b00, 8'hA1);
      exp_push(1, 2'b00, 8'h00);
      rda = 1'b1;
      tbr = 1'b1;
      k = 0;
      while (exp_q.size() != 0 && k < 50) begin
         @(posedge clk);
         k++;
      end
      #1 rda = 1'b0;
`ifdef ECHO_EN
      repeat (3) exp_push(0, 2'b00, 8'h41);
`endif
      drain(40, "round robin");
      chk("rx_valid pulse count", 32'(rx_cnt - rx0), 3);

      // br_cfg change during a TX write
      exp_push(0, 2'b00, 8'h5A);
      kbd_databus = 8'h5A;
      kbd_rda = 1'b1;
      k = 0;
      @(negedge clk);
      while (!(iocs && !iorw) && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("tx write seen", {iocs, iorw}, 2'b10);
      br_cfg = tbl[0].br;
      exp_push(0, 2'b10, tbl[0].lo);
      exp_push(0, 2'b11, tbl[0].hi);
      chk("cfg_done held during tx", cfg_done, 1);
      @(posedge clk);
      #1 kbd_rda = 1'b0;
      wait_cfg(0, "cfg_done drop br 11");
      wait_cfg(1, "cfg_done rise br 11");
      drain(20, "reconfig br 11");

      for (int i = 1; i < 4; i++) begin
         exp_push(0, 2'b10, tbl[i].lo);
         exp_push(0, 2'b11, tbl[i].hi);
         br_cfg = tbl[i].br;
         wait_cfg(0, "cfg_done drop");
         wait_cfg(1, "cfg_done rise");
         drain(20, "reconfig");
      end

`ifdef ECHO_EN
      // Echo byte collides with a keyboard push: keyboard byte first
      tbr = 1'b0;
      spart_rd = 8'h55;
      exp_rx = 8'h55;
      exp_push(1, 2'b00, 8'h00);
      rda = 1'b1;
      @(posedge clk);
      #1 rda = 1'b0;
      kbd_databus = 8'h66;
      kbd_rda = 1'b1;
      repeat (2) @(posedge clk);
      #1 kbd_rda = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      exp_push(0, 2'b00, 8'h66);
      exp_push(0, 2'b00, 8'h55);
      tbr = 1'b1;
      drain(30, "echo order");
`endif

      // Async reset in the middle of an access
      exp_push(0, 2'b00, 8'h77);
      kbd_databus = 8'h77;
      kbd_rda = 1'b1;
      k = 0;
      @(negedge clk);
      while (!iocs && k < 10) begin
         @(negedge clk);
         k++;
      end
      #2 rst = 1'b1;
      #1;
      chk("iocs drops on async rst", iocs, 0);
      chk("cfg_done cleared by rst", cfg_done, 0);
      chk("overflow cleared by rst", overflow, 0);
      chk("fifo emptied by rst", 32'(dut.cnt_q), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
